player_status_tracker: RTL
==========================

Name: player_status_tracker

Overview:
- Per-player status keeper; one instance per tank (green, yellow).
- Turns raw collision levels into the status values the game-control FSM consumes: death count, gold count and mother-base-hit flag.
- Also sequences the tank's explode/respawn/invulnerability life cycle.
- Sits between the collision-detection logic and the game-control FSM; frame-paced by startOfFrame.

Parameters:
- EXPLODE_FRAMES, 30, frames spent in explosion before respawn
- INVULN_FRAMES, 120, frames of post-respawn invulnerability
- BLINK_FRAMES, 8, half-period (frames) of tank blink while invulnerable
- MAX_DEATHS, 3, death count at which the player is out (fits 2 bits)
- MAX_GOLD, 7, gold saturation value (fits 3 bits)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-clk pulse per video frame
- enable_game  in  1  high while the game-control FSM is in play
- idle  in  1  one-clk pulse from the game-control FSM on new-game start; synchronous clear
- hit_by_bullet  in  1  level: enemy bullet overlaps this tank
- gold_collision  in  1  level: this tank overlaps a gold item
- base_hit  in  1  level: enemy bullet overlaps this player's mother base
- deathcount  out  2  deaths so far, saturating at MAX_DEATHS
- num_of_gold  out  3  gold collected, saturating at MAX_GOLD
- mother_base  out  1  sticky: own base destroyed
- respawn  out  1  one-clk pulse: tank position logic reloads start coordinates
- exploding  out  1  high in EXPLODE_ST, selects explosion bitmap
- tank_visible  out  1  draw-enable for the tank bitmap

Behaviour:
- Reset (async) and idle pulse (sync, highest priority) both give: state ALIVE_ST, deathcount=0, num_of_gold=0, mother_base=0, respawn=0, exploding=0, tank_visible=1, frame counter=0, edge registers=0.
- Each level input passes through a rising-edge detector (registered previous value). An event is counted once per rising edge; a held level never re-counts. Event pulse latency is 1 clk after the input rises.
- All events are ignored while enable_game=0. Edge registers still track their inputs, so no false edge appears when enable_game rises.
- Gold event: num_of_gold++ saturating at MAX_GOLD; accepted in every state except OUT_ST.
- Base event: mother_base<=1, sticky until reset or idle.
- States:
  - ALIVE_ST: tank_visible=1. A hit event gives deathcount++ (saturating). If the new value equals MAX_DEATHS, go to OUT_ST; otherwise go to EXPLODE_ST with counter=0.
  - EXPLODE_ST: exploding=1, tank_visible=0. Counter increments on startOfFrame. When counter reaches EXPLODE_FRAMES-1 on a startOfFrame: assert respawn for 1 clk, counter=0, go to INVULN_ST.
  - INVULN_ST: hit events ignored. tank_visible toggles every BLINK_FRAMES frames, starting visible. After INVULN_FRAMES frames, go to ALIVE_ST.
  - OUT_ST: tank_visible=0, exploding=0. Terminal until reset or idle.
- Simultaneous events: hit and gold in the same clk are both applied. idle together with any event means idle wins and the event is discarded.
- While enable_game=0: frame counters freeze and the state holds; outputs keep their values so the win screens can read final counts.

Optional Feature:
- Macro: PLAYER_STATUS_BONUS_LIFE_EN.
- Defined: the first gold event that makes num_of_gold reach 4 also decrements deathcount by 1 if it is nonzero. This happens once per game; the one-shot flag is cleared by reset and by idle.
- Not defined: gold has no effect on deathcount; the flag logic is absent.

Decomposition:
- Shared package game_status_pkg holds:
  - the state enum {ALIVE_ST, EXPLODE_ST, INVULN_ST, OUT_ST}
  - default frame constants
  - the width localparams DEATH_W=2 and GOLD_W=3, also used by the game-control FSM.
- Sub-module rise_edge_det (clk, resetN, enable, level → pulse), instantiated three times.

Test Plan:
- Reset, then enable_game=1, then hit_by_bullet held high for 500 clks: deathcount=1, exploding=1 for 30 frames, one respawn pulse, INVULN_ST for 120 frames with tank_visible toggling every 8 frames, then ALIVE_ST.
- Three hit events, each separated by more than 150 frames: deathcount goes 1, 2, 3; OUT_ST; tank_visible=0; no third respawn pulse.
- Nine gold pulses: num_of_gold goes 1..7 and stays at 7.
- Hit during INVULN_ST: deathcount unchanged. Hit and gold rising in the same clk while ALIVE_ST: deathcount+1 and num_of_gold+1.
- base_hit pulse: mother_base=1 and stays 1. Then idle pulse coincident with a gold rising edge: all outputs return to reset values and num_of_gold=0.
- enable_game=0 mid-EXPLODE_ST for 50 frames: counter frozen. Re-enable: exactly the remaining frames elapse before respawn. Inputs already high at re-enable: no event counted.

Source files
------------

// File: rtl/game_status_pkg.sv
// Shared status types and constants for the player status tracker and the
// game-control FSM: life-cycle state enum, counter widths, default frame
// timings and saturating-increment helpers.
package game_status_pkg;

    localparam int DEATH_W     = 2;
    localparam int GOLD_W      = 3;
    localparam int FRAME_CNT_W = 8;

    localparam int EXPLODE_FRAMES_DEF = 30;
    localparam int INVULN_FRAMES_DEF  = 120;
    localparam int BLINK_FRAMES_DEF   = 8;
    localparam int MAX_DEATHS_DEF     = 3;
    localparam int MAX_GOLD_DEF       = 7;

    typedef enum logic [1:0] {
        ALIVE_ST   = 2'd0,
        EXPLODE_ST = 2'd1,
        INVULN_ST  = 2'd2,
        OUT_ST     = 2'd3
    } state_t;

    function automatic logic [DEATH_W-1:0] sat_inc_death(
        input logic [DEATH_W-1:0] value,
        input logic [DEATH_W-1:0] limit
    );
        return (value >= limit) ? value : value + DEATH_W'(1);
    endfunction

    function automatic logic [GOLD_W-1:0] sat_inc_gold(
        input logic [GOLD_W-1:0] value,
        input logic [GOLD_W-1:0] limit
    );
        return (value >= limit) ? value : value + GOLD_W'(1);
    endfunction

endpackage

// File: rtl/rise_edge_det.sv
// Rising-edge detector for a level input. The previous-value register always
// tracks the input, so a level that rises while disabled never produces a
// late event once enable returns. clear wins over any edge in the same clk.
module rise_edge_det (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic enable,
    input  logic level,
    output logic pulse
);

    logic prev_r;

    // Remember the level seen at the previous clock edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev_r <= 1'b0;
        end else if (clear) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level;
        end
    end

    assign pulse = enable & level & ~prev_r & ~clear;

endmodule

// File: rtl/player_status_tracker.sv
// Per-tank status keeper: death/gold counters, sticky mother-base flag and
// the explode / respawn / invulnerable-blink life cycle, paced by startOfFrame.
// Optional build macro: PLAYER_STATUS_BONUS_LIFE_EN (first time gold reaches 4
// in a game, one death is forgiven).
module player_status_tracker
    import game_status_pkg::*;
#(
    parameter int EXPLODE_FRAMES = EXPLODE_FRAMES_DEF,
    parameter int INVULN_FRAMES  = INVULN_FRAMES_DEF,
    parameter int BLINK_FRAMES   = BLINK_FRAMES_DEF,
    parameter int MAX_DEATHS     = MAX_DEATHS_DEF,
    parameter int MAX_GOLD       = MAX_GOLD_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable_game,
    input  logic               idle,
    input  logic               hit_by_bullet,
    input  logic               gold_collision,
    input  logic               base_hit,
    output logic [DEATH_W-1:0] deathcount,
    output logic [GOLD_W-1:0]  num_of_gold,
    output logic               mother_base,
    output logic               respawn,
    output logic               exploding,
    output logic               tank_visible
);

    state_t                 state_r, state_s;
    logic [DEATH_W-1:0]     death_r, death_s;
    logic [GOLD_W-1:0]      gold_r, gold_s;
    logic                   base_r, base_s;
    logic                   respawn_r, respawn_s;
    logic                   exploding_r, exploding_s;
    logic                   visible_r, visible_s;
    logic [FRAME_CNT_W-1:0] frame_cnt_r, frame_cnt_s;
    logic [FRAME_CNT_W-1:0] blink_cnt_r, blink_cnt_s;
    logic                   hit_ev_s, gold_ev_s, base_ev_s, frame_tick_s;
`ifdef PLAYER_STATUS_BONUS_LIFE_EN
    logic                   bonus_used_r, bonus_used_s;
`endif

    rise_edge_det u_hit_det (
        .clk(clk), .resetN(resetN), .clear(idle), .enable(enable_game),
        .level(hit_by_bullet), .pulse(hit_ev_s)
    );

    rise_edge_det u_gold_det (
        .clk(clk), .resetN(resetN), .clear(idle), .enable(enable_game),
        .level(gold_collision), .pulse(gold_ev_s)
    );

    rise_edge_det u_base_det (
        .clk(clk), .resetN(resetN), .clear(idle), .enable(enable_game),
        .level(base_hit), .pulse(base_ev_s)
    );

    assign frame_tick_s = startOfFrame & enable_game;

    // Next-state logic: counters, life-cycle transitions and output values.
    always_comb begin
        state_s     = state_r;
        death_s     = death_r;
        gold_s      = gold_r;
        base_s      = base_r;
        respawn_s   = 1'b0;
        exploding_s = exploding_r;
        visible_s   = visible_r;
        frame_cnt_s = frame_cnt_r;
        blink_cnt_s = blink_cnt_r;
`ifdef PLAYER_STATUS_BONUS_LIFE_EN
        bonus_used_s = bonus_used_r;
`endif

        if (base_ev_s) begin
            base_s = 1'b1;
        end else begin
            base_s = base_r;
        end

        if (gold_ev_s && (state_r != OUT_ST)) begin
            gold_s = sat_inc_gold(gold_r, GOLD_W'(MAX_GOLD));
        end else begin
            gold_s = gold_r;
        end

        case (state_r)
            ALIVE_ST: begin
                exploding_s = 1'b0;
                visible_s   = 1'b1;
                if (hit_ev_s) begin
                    death_s     = sat_inc_death(death_r, DEATH_W'(MAX_DEATHS));
                    frame_cnt_s = {FRAME_CNT_W{1'b0}};
                    visible_s   = 1'b0;
                    if (death_s == DEATH_W'(MAX_DEATHS)) begin
                        state_s = OUT_ST;
                    end else begin
                        state_s     = EXPLODE_ST;
                        exploding_s = 1'b1;
                    end
                end else begin
                    state_s = ALIVE_ST;
                end
            end
            EXPLODE_ST: begin
                if (frame_tick_s) begin
                    if (frame_cnt_r == FRAME_CNT_W'(EXPLODE_FRAMES - 1)) begin
                        respawn_s   = 1'b1;
                        frame_cnt_s = {FRAME_CNT_W{1'b0}};
                        blink_cnt_s = {FRAME_CNT_W{1'b0}};
                        state_s     = INVULN_ST;
                        exploding_s = 1'b0;
                        visible_s   = 1'b1;
                    end else begin
                        frame_cnt_s = frame_cnt_r + FRAME_CNT_W'(1);
                    end
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            INVULN_ST: begin
                if (frame_tick_s) begin
                    if (frame_cnt_r == FRAME_CNT_W'(INVULN_FRAMES - 1)) begin
                        frame_cnt_s = {FRAME_CNT_W{1'b0}};
                        state_s     = ALIVE_ST;
                        visible_s   = 1'b1;
                    end else begin
                        frame_cnt_s = frame_cnt_r + FRAME_CNT_W'(1);
                        // Blink: flip visibility after every BLINK_FRAMES frames.
                        if (blink_cnt_r == FRAME_CNT_W'(BLINK_FRAMES - 1)) begin
                            blink_cnt_s = {FRAME_CNT_W{1'b0}};
                            visible_s   = ~visible_r;
                        end else begin
                            blink_cnt_s = blink_cnt_r + FRAME_CNT_W'(1);
                        end
                    end
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            OUT_ST: begin
                exploding_s = 1'b0;
                visible_s   = 1'b0;
            end
            default: begin
                state_s     = ALIVE_ST;
                exploding_s = 1'b0;
                visible_s   = 1'b1;
            end
        endcase

`ifdef PLAYER_STATUS_BONUS_LIFE_EN
        // One bonus life per game, granted when gold first climbs to 4.
        if (gold_ev_s && !bonus_used_r && (gold_s == GOLD_W'(4)) && (gold_r != GOLD_W'(4))) begin
            bonus_used_s = 1'b1;
            if (death_s != DEATH_W'(0)) begin
                death_s = death_s - DEATH_W'(1);
            end else begin
                death_s = death_s;
            end
        end else begin
            bonus_used_s = bonus_used_r;
        end
`endif

        // A new-game pulse overrides everything computed above.
        if (idle) begin
            state_s     = ALIVE_ST;
            death_s     = {DEATH_W{1'b0}};
            gold_s      = {GOLD_W{1'b0}};
            base_s      = 1'b0;
            respawn_s   = 1'b0;
            exploding_s = 1'b0;
            visible_s   = 1'b1;
            frame_cnt_s = {FRAME_CNT_W{1'b0}};
            blink_cnt_s = {FRAME_CNT_W{1'b0}};
`ifdef PLAYER_STATUS_BONUS_LIFE_EN
            bonus_used_s = 1'b0;
`endif
        end else begin
            state_s = state_s;
        end
    end

    // Status and life-cycle registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= ALIVE_ST;
            death_r     <= {DEATH_W{1'b0}};
            gold_r      <= {GOLD_W{1'b0}};
            base_r      <= 1'b0;
            respawn_r   <= 1'b0;
            exploding_r <= 1'b0;
            visible_r   <= 1'b1;
            frame_cnt_r <= {FRAME_CNT_W{1'b0}};
            blink_cnt_r <= {FRAME_CNT_W{1'b0}};
`ifdef PLAYER_STATUS_BONUS_LIFE_EN
            bonus_used_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            death_r     <= death_s;
            gold_r      <= gold_s;
            base_r      <= base_s;
            respawn_r   <= respawn_s;
            exploding_r <= exploding_s;
            visible_r   <= visible_s;
            frame_cnt_r <= frame_cnt_s;
            blink_cnt_r <= blink_cnt_s;
`ifdef PLAYER_STATUS_BONUS_LIFE_EN
            bonus_used_r <= bonus_used_s;
`endif
        end
    end

    assign deathcount   = death_r;
    assign num_of_gold  = gold_r;
    assign mother_base  = base_r;
    assign respawn      = respawn_r;
    assign exploding    = exploding_r;
    assign tank_visible = visible_r;

endmodule
